// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg : shared UART transmitter types and constants           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package uart_pkg;

    localparam int unsigned c_clks_per_bit_default = 868;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } uart_tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_baud_cnt : bit-period counter, pulses bit_done on last cycle|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = c_clks_per_bit_default
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_done
);

    localparam int unsigned           c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0]    c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_at_last;

    assign w_at_last = (r_cnt == c_last);
    assign bit_done  = enable && w_at_last;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_at_last ? '0 : r_cnt + c_cnt_w'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx : 8N1 serial transmitter popping bytes from a FIFO       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = c_clks_per_bit_default
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy
);

    uart_tx_state_t r_state, w_state_next;
    logic [7:0]     r_shift, w_shift_next;
    logic [2:0]     r_bit_idx, w_bit_idx_next;
    logic           r_tx, w_tx_next;
    logic           r_fifo_rd_en;
    logic           w_in_frame;
    logic           w_bit_done;

    assign w_in_frame = (r_state == START) || (r_state == DATA) || (r_state == STOP);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!w_in_frame),
        .enable   (w_in_frame),
        .bit_done (w_bit_done)
    );

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        case (r_state)
            IDLE:  if (tx_en && !fifo_empty) w_state_next = POP;
            POP:   w_state_next = LOAD;
            LOAD: begin
                w_shift_next   = fifo_data;
                w_bit_idx_next = 3'd0;
                w_state_next   = START;
            end
            START: if (w_bit_done) w_state_next = DATA;
            DATA: begin
                if (w_bit_done) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_next = 3'd0;
                        w_state_next   = STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            STOP:  if (w_bit_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase

        // Line level is decoded from the upcoming state so the flop lines up with the state.
        w_tx_next = 1'b1;
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_shift      <= 8'h00;
            r_bit_idx    <= 3'd0;
            r_tx         <= 1'b1;
            r_fifo_rd_en <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_shift      <= w_shift_next;
            r_bit_idx    <= w_bit_idx_next;
            r_tx         <= w_tx_next;
            r_fifo_rd_en <= (w_state_next == POP);
        end
    end

    assign tx         = r_tx;
    assign fifo_rd_en = r_fifo_rd_en;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per serial bit (100 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port tx_en  input  1  permit start of a new byte; does not abort a byte in flight.
REQ-005 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 SHALL have port fifo_data  input  8  upstream FIFO read data, valid the cycle after fifo_rd_en.
REQ-007 SHALL have port fifo_rd_en  output  1  single-cycle pop strobe to upstream FIFO.
REQ-008 SHALL have port tx  output  1  serial line, idle high, 8N1 framing, LSB first.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, POP, LOAD, START, DATA, STOP.
REQ-011 IDLE: if tx_en=1 and fifo_empty=0, go to POP next cycle; else stay.
REQ-012 POP: fifo_rd_en=1 for exactly this one cycle; go to LOAD.
REQ-013 LOAD: capture fifo_data into 8-bit shift register; go to START.
REQ-014 START: tx=0 for CLKS_PER_BIT cycles; go to DATA.
REQ-015 DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shift right after each bit, 8 bits total, bit index 0..7; go to STOP after bit 7.
REQ-016 STOP: tx=1 for CLKS_PER_BIT cycles; go to IDLE.
REQ-017 fifo_rd_en SHALL be a registered Moore output (state==POP) and SHALL never be high while fifo_empty=1 at the same edge.
REQ-018 tx SHALL be registered and glitch-free; tx=1 in IDLE, POP, LOAD.
REQ-019 Baud counter SHALL count 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT), wrap to 0 on each bit boundary, and be held at 0 outside START/DATA/STOP.
REQ-020 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles from first tx=0 to end of stop bit.
REQ-021 Back-to-back bytes: gap between stop-bit end and next start bit SHALL be exactly 3 cycles (IDLE, POP, LOAD) when tx_en=1 and fifo_empty=0.
REQ-022 tx_en deasserted mid-frame SHALL NOT affect the current frame; FSM returns to IDLE and waits.
REQ-023 fifo_empty changes during a frame SHALL be ignored until IDLE.

Reset
REQ-024 On rst_n=0 at a clk edge: state=IDLE, tx=1, fifo_rd_en=0, busy=0, baud counter=0, bit index=0, shift register=0x00.
REQ-025 Reset mid-frame SHALL abort immediately; tx=1 from the cycle after the reset edge; the partial byte is discarded, not re-popped.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state enum (uart_tx_state_t) and default CLKS_PER_BIT constant.
REQ-027 Baud counter SHALL be a sub-module uart_baud_cnt (clear, enable, bit_done pulse); everything else SHALL stay in uart_tx.

Verification (bench: CLKS_PER_BIT=4, fifo instance with registered read upstream)
REQ-028 Push 0xA5, tx_en=1 -> tx: 0 for 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, then 1 for 4 cycles; frame 40 cycles; one fifo_rd_en pulse.
REQ-029 Push 0x00,0xFF,0x3C back-to-back -> three frames decoded in order, 3-cycle gaps, fifo empty after third pop, busy low after last stop bit.
REQ-030 FIFO empty, tx_en=1 for 100 cycles -> fifo_rd_en never high, tx stays 1, busy stays 0.
REQ-031 Push 0x55, drop tx_en at bit 3 -> 0x55 frame completes intact; second pushed byte not popped until tx_en=1 again.
REQ-032 Assert rst_n=0 during DATA bit 4 of 0xC3 -> next cycle tx=1, busy=0, fifo_rd_en=0; after release, next queued byte transmits correctly.
REQ-033 All scenarios SHALL run with concurrent assertions: fifo_empty |-> !fifo_rd_en; fifo_rd_en |=> !fifo_rd_en; !busy |-> tx.
